mem_stage_lsu: RTL



---
 rtl/lsu_pkg.sv | 27 ++
 rtl/mem_stage_lsu_if.sv | 32 +++
 rtl/mem_align.sv | 60 ++++++
 rtl/mem_stage_lsu.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the MEM-stage load/store unit: RISC-V funct3 load/store
// widths, FSM state encoding and byte-enable constants.
// No ports (package).
// -----------------------------------------------------------------------------
package lsu_pkg;

  // funct3 encodings for loads/stores; anything else is handled as a word access
  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] BE_BYTE    = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

endpackage

// File: rtl/mem_stage_lsu_if.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu_if
// Data-memory bus between the load/store unit (master) and memory (slave).
//   req    master->slave  request, held until ack
//   we     master->slave  1 = write
//   addr   master->slave  word-aligned byte address
//   be     master->slave  byte enables
//   wdata  master->slave  lane-replicated store data
//   ack    slave->master  single-cycle completion pulse
//   rdata  slave->master  read word, valid with ack
// -----------------------------------------------------------------------------
interface mem_stage_lsu_if;

  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output ack, rdata
  );

endinterface

// File: rtl/mem_align.sv
// -----------------------------------------------------------------------------
// mem_align
// Purely combinational byte-lane logic for the load/store unit.
//   st_op, st_lo, st_wdata   incoming access: funct3, addr[1:0], store data
//   st_be, st_lane           byte enables and lane-replicated store data
//   st_misalign              access violates its natural alignment
//   ld_op, ld_lo, ld_rdata   captured load funct3, addr[1:0] and bus read word
//   ld_data                  extracted and sign/zero-extended load result
// -----------------------------------------------------------------------------
module mem_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_op,
  input  logic [1:0]  st_lo,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_lane,
  output logic        st_misalign,
  input  logic [2:0]  ld_op,
  input  logic [1:0]  ld_lo,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] sh;

  // NOTE: every output of an always_comb gets a default first so no path
  // through the case leaves it unassigned (which would infer a latch).
  always_comb begin
    st_be       = BE_WORD;
    st_lane     = st_wdata;
    st_misalign = 1'b0;
    case (st_op)
      OP_B, OP_BU: begin
        st_be   = BE_BYTE << st_lo;
        st_lane = {4{st_wdata[7:0]}};
      end
      OP_H, OP_HU: begin
        st_be       = st_lo[1] ? BE_HALF_HI : BE_HALF_LO;
        st_lane     = {2{st_wdata[15:0]}};
        st_misalign = st_lo[0];
      end
      // OP_W and the undefined encodings are word accesses
      default: st_misalign = |st_lo;
    endcase
  end

  always_comb begin
    // Move the addressed byte/half down to bit 0 before extending
    sh = ld_rdata >> {ld_lo, 3'b000};
    case (ld_op)
      OP_B:    ld_data = {{24{sh[7]}}, sh[7:0]};
      OP_BU:   ld_data = {24'h0, sh[7:0]};
      OP_H:    ld_data = {{16{sh[15]}}, sh[15:0]};
      OP_HU:   ld_data = {16'h0, sh[15:0]};
      default: ld_data = sh;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu
// MEM-stage load/store unit. Turns the registered EX/MEM load/store request into
// a req/ack data-memory transaction, stalls the pipeline until it completes, and
// reports misaligned accesses and bus timeouts with the completion pulse.
//   clk, rst     clock; asynchronous active-high reset
//   mem_read     load request          mem_write  store request (wins over read)
//   mem_op       funct3 width/sign     addr       byte address
//   wdata        store data            stall      hold IF..EX/MEM registers
//   load_data    formatted load result (held until next load/error completion)
//   mem_done     one-cycle completion pulse
//   misalign     with mem_done: access was misaligned, no bus cycle issued
//   bus_err      with mem_done: no ack within TIMEOUT busy cycles
//   dmem         data-memory bus (master side)
// TIMEOUT: busy cycles without ack before abort; 0 waits forever.
// -----------------------------------------------------------------------------
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [2:0]             mem_op,
  input  logic [31:0]            addr,
  input  logic [31:0]            wdata,
  output logic                   stall,
  output logic [31:0]            load_data,
  output logic                   mem_done,
  output logic                   misalign,
  output logic                   bus_err,
  mem_stage_lsu_if.master        dmem
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t             state;
  state_t             state_next;
  logic               access;
  logic               timeout_hit;
  logic [CNT_W-1:0]   count;
  logic [2:0]         op_q;
  logic [1:0]         lo_q;
  logic               mis_q;
  logic               berr_q;
  logic [3:0]         be_c;
  logic [31:0]        lane_c;
  logic               misalign_c;
  logic [31:0]        ld_fmt;

  assign access      = mem_read | mem_write;
  assign timeout_hit = (TIMEOUT != 0) && (count == CNT_W'(TIMEOUT - 1));

  mem_align u_align (
    .st_op       (mem_op),
    .st_lo       (addr[1:0]),
    .st_wdata    (wdata),
    .st_be       (be_c),
    .st_lane     (lane_c),
    .st_misalign (misalign_c),
    .ld_op       (op_q),
    .ld_lo       (lo_q),
    .ld_rdata    (dmem.rdata),
    .ld_data     (ld_fmt)
  );

  // State register; reset drops the bus request at once since req is decoded
  // from BUSY.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (access) state_next = misalign_c ? DONE : BUSY;
      BUSY:    if (dmem.ack || timeout_hit) state_next = DONE;
      DONE:    state_next = IDLE;  // EX/MEM still shows the finished access
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    stall    = ((state == IDLE) && access) || (state == BUSY);
    dmem.req = (state == BUSY);
    mem_done = (state == DONE);
    misalign = (state == DONE) && mis_q;
    bus_err  = (state == DONE) && berr_q;
  end

  // Request capture, timeout counter, load result and error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem.we    <= 1'b0;
      dmem.addr  <= '0;
      dmem.be    <= '0;
      dmem.wdata <= '0;
      op_q       <= '0;
      lo_q       <= '0;
      count      <= '0;
      load_data  <= '0;
      mis_q      <= 1'b0;
      berr_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          count  <= '0;
          mis_q  <= 1'b0;
          berr_q <= 1'b0;
          if (access) begin
            if (misalign_c) begin
              mis_q     <= 1'b1;
              load_data <= '0;
            end else begin
              dmem.we    <= mem_write;
              dmem.addr  <= {addr[31:2], 2'b00};
              dmem.be    <= be_c;
              dmem.wdata <= lane_c;
              op_q       <= mem_op;
              lo_q       <= addr[1:0];
            end
          end
        end
        BUSY: begin
          if (dmem.ack) begin
            if (!dmem.we) load_data <= ld_fmt;
          end else if (timeout_hit) begin
            berr_q    <= 1'b1;
            load_data <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
